// File: rtl/dunc16_memctl_if.sv
// Bus and loader signals between the dunc16 CPU memory port and the memory controller.
interface dunc16_memctl_if;
    logic        REQ;
    logic        WE;
    logic [15:0] ADDR;
    logic [15:0] WDATA;
    logic [15:0] RDATA;
    logic        ACK;
    logic        ERR;
    logic        BUSY;
    logic        LD_WE;
    logic [15:0] LD_ADDR;
    logic [15:0] LD_DATA;

    modport master (
        output REQ, WE, ADDR, WDATA, LD_WE, LD_ADDR, LD_DATA,
        input  RDATA, ACK, ERR, BUSY
    );

    modport slave (
        input  REQ, WE, ADDR, WDATA, LD_WE, LD_ADDR, LD_DATA,
        output RDATA, ACK, ERR, BUSY
    );
endinterface

// File: rtl/dunc16_memctl.sv
// dunc16 memory responder: single-word bus reads/writes on an internal RAM with
// programmable wait states, write protection of low memory and a side-band loader.
module dunc16_memctl #(
    parameter int unsigned AW       = 12,
    parameter int unsigned WAIT     = 1,
    parameter logic [15:0] WP_LIMIT = 16'h0010
) (
    input  logic            CLK,
    input  logic            RESET_N,
    dunc16_memctl_if.slave  bus
);
    localparam int unsigned DW    = 16;
    localparam int unsigned CW    = 4;
    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAITS,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_we;
    logic [DW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_rdata;
    logic            r_ack;
    logic            r_err;
    logic            r_busy;
    logic [DW-1:0]   r_ram [DEPTH];

    logic            w_oor;
    logic            w_prot;
    logic            w_reject;
    logic            w_ld_wr;
    logic            w_bus_wr;
    logic            w_unused_ld_addr;

    // Rejection is judged on the latched request, so it is stable throughout ACCESS.
    assign w_oor    = (r_addr >> AW) != 16'd0;
    assign w_prot   = r_we && (r_addr < WP_LIMIT);
    assign w_reject = w_oor || w_prot;
    assign w_ld_wr  = (r_state == S_IDLE) && bus.LD_WE;
    assign w_bus_wr = (r_state == S_ACCESS) && r_we && !w_reject;

    // Loader address aliases into the RAM; upper bits are deliberately dropped.
    assign w_unused_ld_addr = |(bus.LD_ADDR >> AW);

    assign bus.RDATA = r_rdata;
    assign bus.ACK   = r_ack;
    assign bus.ERR   = r_err;
    assign bus.BUSY  = r_busy;

    // RAM has no reset; a reset during ACCESS forces IDLE, which suppresses the write.
    always_ff @(posedge CLK) begin
        if (w_ld_wr) begin
            r_ram[bus.LD_ADDR[AW-1:0]] <= bus.LD_DATA;
        end else if (w_bus_wr) begin
            r_ram[r_addr[AW-1:0]] <= r_wdata;
        end
    end

    // Control FSM with registered bus outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!bus.LD_WE && bus.REQ) begin
                        r_we    <= bus.WE;
                        r_addr  <= bus.ADDR;
                        r_wdata <= bus.WDATA;
                        r_busy  <= 1'b1;
                        if (WAIT == 0) begin
                            r_state <= S_ACCESS;
                        end else begin
                            r_cnt   <= CW'(WAIT);
                            r_state <= S_WAITS;
                        end
                    end
                end
                S_WAITS: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_ack <= 1'b1;
                    r_err <= w_reject;
                    if (!r_we) begin
                        r_rdata <= w_reject ? 16'h0000 : r_ram[r_addr[AW-1:0]];
                    end
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dunc16_memctl.sv
// Directed bench for dunc16_memctl: three instances (WAIT = 0, 1, 3) on one clock,
// a vector table for single transactions and hand sequences for priority and reset.
module tb_dunc16_memctl;
    localparam int ND = 3;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic        req     [ND];
    logic        we      [ND];
    logic        ld_we   [ND];
    logic [15:0] addr    [ND];
    logic [15:0] wdata   [ND];
    logic [15:0] ld_addr [ND];
    logic [15:0] ld_data [ND];
    logic [15:0] rdata   [ND];
    logic        ack     [ND];
    logic        err     [ND];
    logic        busy    [ND];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int unsigned WV = (g == 2) ? 3 : g;
        dunc16_memctl_if bif ();
        assign bif.REQ     = req[g];
        assign bif.WE      = we[g];
        assign bif.ADDR    = addr[g];
        assign bif.WDATA   = wdata[g];
        assign bif.LD_WE   = ld_we[g];
        assign bif.LD_ADDR = ld_addr[g];
        assign bif.LD_DATA = ld_data[g];
        assign rdata[g]    = bif.RDATA;
        assign ack[g]      = bif.ACK;
        assign err[g]      = bif.ERR;
        assign busy[g]     = bif.BUSY;
        dunc16_memctl #(.AW(12), .WAIT(WV), .WP_LIMIT(16'h0010)) u_dut (
            .CLK     (CLK),
            .RESET_N (rst_n),
            .bus     (bif.slave)
        );
    end

    typedef struct {
        int          d;
        bit          ld;
        bit          w;
        logic [15:0] a;
        logic [15:0] wd;
        logic [15:0] exp_rd;
        bit          exp_e;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(int d, bit ld, bit w, logic [15:0] a, logic [15:0] wd,
                                logic [15:0] exp_rd, bit exp_e);
        vec_t v;
        v.d = d; v.ld = ld; v.w = w; v.a = a; v.wd = wd; v.exp_rd = exp_rd; v.exp_e = exp_e;
        return v;
    endfunction

    function automatic int wait_of(int d);
        return (d == 2) ? 3 : d;
    endfunction

    task automatic check(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h", nm, d, got, exp);
        end
    endtask

    task automatic ld_write(input int d, input logic [15:0] a, input logic [15:0] v);
        @(negedge CLK);
        ld_we[d] = 1'b1; ld_addr[d] = a; ld_data[d] = v;
        @(negedge CLK);
        ld_we[d] = 1'b0;
    endtask

    // Waits for ACK (bounded); scrambles ADDR/WDATA once latched; drops REQ on ACK.
    task automatic wait_ack(input int d, output logic [15:0] rd, output logic e,
                            output int c, output int nb);
        c = 0; nb = 0; rd = 16'h0; e = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            if (busy[d]) nb++;
            if (i == 1) begin
                addr[d]  = ~addr[d];
                wdata[d] = ~wdata[d];
            end
            if (ack[d]) begin
                c = i; rd = rdata[d]; e = err[d];
                req[d] = 1'b0;
                break;
            end
        end
        req[d] = 1'b0;
    endtask

    task automatic bus_op(input int d, input logic w, input logic [15:0] a, input logic [15:0] wd,
                          input logic [15:0] exp_rd, input logic exp_e);
        logic [15:0] rd;
        logic        e;
        int          c, nb;
        string       nm;
        nm = $sformatf("%s@%0h", w ? "wr" : "rd", a);
        @(negedge CLK);
        req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
        wait_ack(d, rd, e, c, nb);
        check({nm, " ack_latency"}, d, c, wait_of(d) + 2);
        check({nm, " rdata"}, d, rd, exp_rd);
        check({nm, " err"}, d, e, exp_e);
        check({nm, " busy_cycles"}, d, nb, wait_of(d) + 2);
        @(negedge CLK);
        check({nm, " idle_after"}, d, {ack[d], err[d], busy[d]}, 3'b000);
    endtask

    task automatic check_idle(input string nm);
        for (int d = 0; d < ND; d++)
            check(nm, d, {rdata[d], ack[d], err[d], busy[d]}, 19'h0);
    endtask

    initial begin
        logic [15:0] rd;
        logic        e;
        int          c, nb, seen;

        for (int d = 0; d < ND; d++) begin
            req[d] = 1'b0; we[d] = 1'b0; ld_we[d] = 1'b0;
            addr[d] = '0; wdata[d] = '0; ld_addr[d] = '0; ld_data[d] = '0;
        end
        rst_n = 1'b0;

        // Reset and idle
        repeat (2) @(negedge CLK);
        check_idle("reset_state");
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge CLK);
            check_idle("idle_after_reset");
        end

        // Single-transaction vectors: d=1 is WAIT=1, d=0 is WAIT=0, d=2 is WAIT=3
        vq.push_back(mk(1, 1, 0, 16'h0020, 16'hBEEF, 16'h0000, 0));
        vq.push_back(mk(1, 0, 0, 16'h0020, 16'h0000, 16'hBEEF, 0));
        vq.push_back(mk(1, 1, 0, 16'h0005, 16'h1111, 16'h0000, 0));
        vq.push_back(mk(1, 0, 1, 16'h0005, 16'hFFFF, 16'hBEEF, 1));
        vq.push_back(mk(1, 0, 0, 16'h0005, 16'h0000, 16'h1111, 0));
        vq.push_back(mk(1, 0, 0, 16'h1000, 16'h0000, 16'h0000, 1));
        vq.push_back(mk(1, 1, 0, 16'h0005, 16'h5A5A, 16'h0000, 0));
        vq.push_back(mk(1, 0, 0, 16'h0005, 16'h0000, 16'h5A5A, 0));
        vq.push_back(mk(1, 0, 1, 16'h0300, 16'hCAFE, 16'h5A5A, 0));
        vq.push_back(mk(1, 0, 0, 16'h0300, 16'h0000, 16'hCAFE, 0));
        vq.push_back(mk(1, 0, 1, 16'h0010, 16'h0101, 16'hCAFE, 0));
        vq.push_back(mk(1, 0, 0, 16'h0010, 16'h0000, 16'h0101, 0));
        vq.push_back(mk(1, 0, 1, 16'h000F, 16'h0F0F, 16'h0101, 1));
        vq.push_back(mk(0, 0, 1, 16'h0100, 16'h1234, 16'h0000, 0));
        vq.push_back(mk(0, 0, 0, 16'h0100, 16'h0000, 16'h1234, 0));
        vq.push_back(mk(0, 0, 1, 16'h0FFF, 16'h7E7E, 16'h1234, 0));
        vq.push_back(mk(0, 0, 0, 16'h0FFF, 16'h0000, 16'h7E7E, 0));
        vq.push_back(mk(0, 0, 0, 16'h1FFF, 16'h0000, 16'h0000, 1));
        vq.push_back(mk(0, 0, 1, 16'h8FFF, 16'h1111, 16'h0000, 1));
        vq.push_back(mk(0, 0, 0, 16'h0FFF, 16'h0000, 16'h7E7E, 0));
        vq.push_back(mk(2, 0, 1, 16'h0400, 16'h9999, 16'h0000, 0));
        vq.push_back(mk(2, 0, 0, 16'h0400, 16'h0000, 16'h9999, 0));

        foreach (vq[i]) begin
            if (vq[i].ld) ld_write(vq[i].d, vq[i].a, vq[i].wd);
            else          bus_op(vq[i].d, vq[i].w, vq[i].a, vq[i].wd, vq[i].exp_rd, vq[i].exp_e);
        end

        // Loader and REQ together: loader wins, REQ accepted on the following edge
        @(negedge CLK);
        ld_we[1] = 1'b1; ld_addr[1] = 16'h0040; ld_data[1] = 16'h4242;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0040;
        @(negedge CLK);
        check("prio_not_accepted_on_ld_edge", 1, busy[1], 1'b0);
        ld_we[1] = 1'b0;
        wait_ack(1, rd, e, c, nb);
        check("prio_ack_latency", 1, c, 3);
        check("prio_rdata", 1, rd, 16'h4242);
        @(negedge CLK);

        // LD_WE pulsed while BUSY must not touch the RAM
        ld_write(2, 16'h0060, 16'h1357);
        @(negedge CLK);
        req[2] = 1'b1; we[2] = 1'b0; addr[2] = 16'h0060;
        @(negedge CLK);
        check("ldbusy_busy", 2, busy[2], 1'b1);
        ld_we[2] = 1'b1; ld_addr[2] = 16'h0060; ld_data[2] = 16'hDEAD;
        @(negedge CLK);
        ld_we[2] = 1'b0;
        wait_ack(2, rd, e, c, nb);
        check("ldbusy_rdata", 2, rd, 16'h1357);
        @(negedge CLK);
        bus_op(2, 1'b0, 16'h0060, 16'h0000, 16'h1357, 1'b0);

        // Reset during WAITS abandons the write
        ld_write(2, 16'h0200, 16'h1111);
        @(negedge CLK);
        req[2] = 1'b1; we[2] = 1'b1; addr[2] = 16'h0200; wdata[2] = 16'hAAAA;
        @(negedge CLK);
        check("rst_waits_busy_before", 2, busy[2], 1'b1);
        req[2] = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_waits_busy_after", 2, busy[2], 1'b0);
        @(negedge CLK);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge CLK);
            if (ack[2]) seen++;
        end
        check("rst_waits_no_ack", 2, seen, 0);
        bus_op(2, 1'b0, 16'h0200, 16'h0000, 16'h1111, 1'b0);

        // Reset during DONE drops ACK at once
        ld_write(1, 16'h0070, 16'h0707);
        @(negedge CLK);
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0070;
        wait_ack(1, rd, e, c, nb);
        check("rst_done_rdata", 1, rd, 16'h0707);
        rst_n = 1'b0;
        #1;
        check("rst_done_ack_drop", 1, {ack[1], err[1], busy[1], rdata[1]}, 19'h0);
        @(negedge CLK);
        rst_n = 1'b1;
        repeat (2) @(negedge CLK);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
